// File: rtl/en64_pkg.sv
// en64_pkg: widths, codeword field offsets, injection modes and the Hamming check-mask table.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a. Shared by the en64 encoder and the de64 decode path so both ends use one mask table.
package en64_pkg;

  localparam int DATA_W   = 64;
  localparam int CHK_W    = 7;
  localparam int CODE_W   = 80;
  localparam int PROT_W   = 72;   // data + check + overall parity, covered by even parity
  localparam int RSV_W    = CODE_W - PROT_W;
  localparam int POS_W    = 7;    // width of an injection bit position
  localparam int CHK_PART = 4;    // partial XOR segments per check bit held in S1

  // Codeword field offsets
  localparam int DATA_LSB = 0;
  localparam int CHK_LSB  = 64;
  localparam int PAR_BIT  = 71;
  localparam int RSV_LSB  = 72;

  typedef enum logic [1:0] {
    INJ_NONE     = 2'b00,
    INJ_SINGLE   = 2'b01,
    INJ_DOUBLE   = 2'b10,
    INJ_NONE_ALT = 2'b11
  } inj_mode_e;

  typedef logic [CHK_W-1:0][DATA_W-1:0] chk_mask_t;

  // Walk Hamming positions 1..71; data bits take the non-power-of-two slots in
  // ascending order, and check c[i] covers every data bit whose position has bit i set.
  function automatic chk_mask_t gen_chk_mask();
    chk_mask_t m;
    int        d;
    m = '0;
    d = 0;
    for (int pos = 1; pos < PROT_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int i = 0; i < CHK_W; i++) begin
          m[i][d] = pos[i];
        end
        d++;
      end
    end
    return m;
  endfunction

  localparam chk_mask_t CHK_MASK = gen_chk_mask();

endpackage

// File: rtl/en64_secded_tx_if.sv
// en64_secded_tx_if: input beat and output codeword handshakes for the en64 encoder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; inj_* fields exist only when ENC_ERR_INJ_EN is defined.
interface en64_secded_tx_if;
  import en64_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
`ifdef ENC_ERR_INJ_EN
  inj_mode_e           inj_mode;
  logic [POS_W-1:0]    inj_pos0;
  logic [POS_W-1:0]    inj_pos1;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [CODE_W-1:0]   out_code;

`ifdef ENC_ERR_INJ_EN
  modport master (
    output in_valid, in_data, inj_mode, inj_pos0, inj_pos1, out_ready,
    input  in_ready, out_valid, out_code
  );
  modport slave (
    input  in_valid, in_data, inj_mode, inj_pos0, inj_pos1, out_ready,
    output in_ready, out_valid, out_code
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code
  );
`endif

endinterface

// File: rtl/en64_chk_gen.sv
// en64_chk_gen: masks the data word per check bit and reduces each mask into PARTS segment XORs.
// Latency: combinational; the caller finishes c[i] by XORing the PARTS segments of check i.
// Backpressure: none (no state).
module en64_chk_gen
  import en64_pkg::*;
#(
  parameter int PARTS = CHK_PART
) (
  input  logic [DATA_W-1:0]            data,
  output logic [CHK_W-1:0][PARTS-1:0]  part
);

  localparam int SEG_W = DATA_W / PARTS;

  // Segment-wise masked reduction, split so the final fold fits in the next stage
  always_comb begin
    part = '0;
    for (int i = 0; i < CHK_W; i++) begin
      for (int j = 0; j < PARTS; j++) begin
        part[i][j] = ^(data[j*SEG_W +: SEG_W] & CHK_MASK[i][j*SEG_W +: SEG_W]);
      end
    end
  end

endmodule

// File: rtl/en64_secded_tx.sv
// en64_secded_tx: SECDED encoder, 64-bit data -> 80-bit codeword {8'h00, p, c[6:0], data}. Optional ENC_ERR_INJ_EN adds bit-flip injection.
// Latency: 2 cycles (S1 registers data + partial check XORs; S2 completes c/p, injects, registers out_code).
// Backpressure: in_ready = !s1_valid | !s2_valid | out_ready; out_code is held while out_valid & !out_ready.
module en64_secded_tx
  import en64_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  en64_secded_tx_if.slave  bus,
  output logic [CNT_W-1:0] word_cnt
);

  typedef logic [CHK_W-1:0][CHK_PART-1:0] part_t;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  part_t             s1_part;
  part_t             in_part;
  logic              s2_valid;
  logic [CODE_W-1:0] out_code;

  logic              s1_advance;
  logic              in_ready;
  logic              in_fire;
  logic              out_fire;

  logic [CHK_W-1:0]  s2_chk;
  logic              s2_par;
  logic [PROT_W-1:0] flip;
  logic [CODE_W-1:0] clean_code;
  logic [CODE_W-1:0] next_code;

`ifdef ENC_ERR_INJ_EN
  inj_mode_e         s1_inj_mode;
  logic [POS_W-1:0]  s1_pos0;
  logic [POS_W-1:0]  s1_pos1;
`endif

  assign s1_advance    = !s2_valid || bus.out_ready;
  assign in_ready      = !s1_valid || s1_advance;
  assign in_fire       = bus.in_valid && in_ready;
  assign out_fire      = s2_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_code  = out_code;

  en64_chk_gen #(
    .PARTS (CHK_PART)
  ) u_chk_gen (
    .data (bus.in_data),
    .part (in_part)
  );

  // S1: capture the accepted beat and its partial check reductions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_part  <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_data <= bus.in_data;
        s1_part <= in_part;
      end
    end
  end

`ifdef ENC_ERR_INJ_EN
  // S1: injection controls travel with their beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_inj_mode <= INJ_NONE;
      s1_pos0     <= '0;
      s1_pos1     <= '0;
    end else if (in_fire) begin
      s1_inj_mode <= bus.inj_mode;
      s1_pos0     <= bus.inj_pos0;
      s1_pos1     <= bus.inj_pos1;
    end
  end

  // S2: flip mask; out-of-range positions are ignored, equal positions flip once
  always_comb begin
    flip = '0;
    if ((s1_inj_mode == INJ_SINGLE || s1_inj_mode == INJ_DOUBLE) &&
        (s1_pos0 < POS_W'(PROT_W))) begin
      flip[s1_pos0] = 1'b1;
    end
    if ((s1_inj_mode == INJ_DOUBLE) && (s1_pos1 < POS_W'(PROT_W))) begin
      flip[s1_pos1] = 1'b1;
    end
  end
`else
  assign flip = '0;
`endif

  // S2: fold partials into c[6:0], then even parity over data and checks
  always_comb begin
    s2_chk = '0;
    for (int i = 0; i < CHK_W; i++) begin
      s2_chk[i] = ^s1_part[i];
    end
    s2_par = ^{s1_data, s2_chk};
  end

  // S2: assemble the codeword fields and apply the injection flips to [71:0]
  always_comb begin
    clean_code                        = '0;
    clean_code[DATA_LSB +: DATA_W]    = s1_data;
    clean_code[CHK_LSB +: CHK_W]      = s2_chk;
    clean_code[PAR_BIT]               = s2_par;
    clean_code[RSV_LSB +: RSV_W]      = '0;
    next_code                         = clean_code ^ {{RSV_W{1'b0}}, flip};
  end

  // S2: output register, only moves when the downstream slot frees up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_code <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_code <= next_code;
      end
    end
  end

  // Count codewords taken by the downstream, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (out_fire) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_en64_secded_tx.sv
// tb_en64_secded_tx: scoreboard bench for en64_secded_tx against a position-walk Hamming model.
// Latency: expects codewords two edges after the beat is presented, in order.
// Backpressure: exercises stalls, combinational in_ready release and mid-stream reset.
module tb_en64_secded_tx;
  import en64_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] word_cnt;

  en64_secded_tx_if bus ();

  en64_secded_tx #(
    .CNT_W (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  int          run_len = 0;
  int          max_run = 0;
  logic [79:0] exp_q[$];

  // Reference: walk positions 1..71, data bits fill non-powers-of-two; the check
  // field is the XOR of the positions of all set data bits, p makes [71:0] even.
  function automatic logic [79:0] model(input logic [63:0] d, input logic [1:0] mode,
                                        input int p0, input int p1);
    logic [79:0] cw;
    int          syn;
    int          k;
    cw       = '0;
    cw[63:0] = d;
    syn      = 0;
    k        = 0;
    for (int pos = 1; pos <= 71; pos++) begin
      if ($countones(pos) != 1) begin
        if (d[k]) syn = syn ^ pos;
        k++;
      end
    end
    cw[70:64] = syn[6:0];
    cw[71]    = ^cw[70:0];
    if ((mode == 2'b01 || mode == 2'b10) && p0 <= 71) cw[p0] = ~cw[p0];
    if (mode == 2'b10 && p1 != p0 && p1 <= 71) cw[p1] = ~cw[p1];
    return cw;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic set_inj(input logic [1:0] mode, input int p0, input int p1);
`ifdef ENC_ERR_INJ_EN
    bus.inj_mode = inj_mode_e'(mode);
    bus.inj_pos0 = 7'(p0);
    bus.inj_pos1 = 7'(p1);
`else
    if (mode != 2'b00 || p0 != 0 || p1 != 0) $display("note: injection ignored in this build");
`endif
  endtask

  // Monitor: push expectations on input transfers, compare head on every valid output
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
`ifdef ENC_ERR_INJ_EN
        exp_q.push_back(model(bus.in_data, bus.inj_mode, int'(bus.inj_pos0), int'(bus.inj_pos1)));
`else
        exp_q.push_back(model(bus.in_data, 2'b00, 0, 0));
`endif
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", bus.out_code, 80'h0);
          n_err += (bus.out_code === 80'h0) ? 1 : 0;
        end else begin
          chk("out_code", bus.out_code, exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            exp_cnt++;
          end
        end
      end
      if (bus.out_valid && bus.out_ready) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  // One beat into an empty pipeline; called just after a rising edge
  task automatic send_one(input logic [63:0] d, input logic [1:0] mode, input int p0,
                          input int p1, input logic [7:0] exp_hi, output logic [79:0] got);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    set_inj(mode, p0, p1);
    @(negedge clk);
    chk("idle_in_ready", 80'(bus.in_ready), 80'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    set_inj(2'b00, 0, 0);
    @(negedge clk);
    chk("lat_early", 80'(bus.out_valid), 80'(0));
    @(posedge clk);
    @(negedge clk);
    chk("lat_due", 80'(bus.out_valid), 80'(1));
    chk("code_hi", 80'(bus.out_code[71:64]), 80'(exp_hi));
    got = bus.out_code;
    @(posedge clk); #1;
    chk("word_cnt", 80'(word_cnt), 80'(exp_cnt));
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 80'(exp_q.size()), 80'(0));
    chk({nm, "_cnt"}, 80'(word_cnt), 80'(exp_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] got;
    logic [79:0] e;
    logic [63:0] d;
    int          acc;
    logic        took;

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = {$urandom(), $urandom()};
    bus.out_ready = 1'b1;
    set_inj(2'b00, 0, 0);

    // Reset state; a valid beat during reset must not be captured
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 80'(bus.out_valid), 80'(0));
    chk("rst_out_code", bus.out_code, 80'h0);
    chk("rst_word_cnt", 80'(word_cnt), 80'(0));
    chk("rst_in_ready", 80'(bus.in_ready), 80'(1));
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("no_xfer_in_rst", 80'(bus.out_valid), 80'(0));
    @(posedge clk); #1;

    // Directed known codewords
    send_one(64'h0, 2'b00, 0, 0, 8'h00, got);
    chk("zero_code", got, 80'h0);
    send_one(64'h1, 2'b00, 0, 0, 8'h83, got);
    send_one(64'h2, 2'b00, 0, 0, 8'h85, got);

    // 16 back-to-back random words
    max_run = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {$urandom(), $urandom()};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("b2b_in_ready", 80'(bus.in_ready), 80'(1));
      @(posedge clk); #1;
      if (i < 15) bus.in_data = {$urandom(), $urandom()};
      else bus.in_valid = 1'b0;
    end
    wait_drain("b2b_drain");
    chk("b2b_run", 80'(max_run), 80'(16));
    chk("b2b_word_cnt", 80'(word_cnt), 80'(19));

    // Stall: out_ready low for 5 cycles with input offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = {$urandom(), $urandom()};
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_in_ready", 80'(bus.in_ready), 80'((c < 2) ? 1 : 0));
      took = bus.in_ready;
      if (took) acc++;
      @(posedge clk); #1;
      if (took) bus.in_data = {$urandom(), $urandom()};
    end
    chk("stall_buffered", 80'(acc), 80'(2));
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 80'(bus.in_ready), 80'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain("stall_drain");

    // Fill both stages, then reset mid-stream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.in_data = {$urandom(), $urandom()};
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", 80'(bus.out_valid), 80'(1));
    chk("full_in_ready", 80'(bus.in_ready), 80'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    chk("arst_out_valid", 80'(bus.out_valid), 80'(0));
    chk("arst_word_cnt", 80'(word_cnt), 80'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("arst_discard", 80'(bus.out_valid), 80'(0));
    @(posedge clk); #1;
    d = {$urandom(), $urandom()};
    e = model(d, 2'b00, 0, 0);
    send_one(d, 2'b00, 0, 0, e[71:64], got);

`ifdef ENC_ERR_INJ_EN
    // Injection: single flip of data bit 3
    e = model(64'h1, 2'b01, 3, 0);
    send_one(64'h1, 2'b01, 3, 0, e[71:64], got);
    chk("inj_single_bit3", 80'(got[3]), 80'(1));
    chk("inj_single_par", 80'(^got[71:0]), 80'(1));
    // Double flip keeps even parity but breaks the syndrome
    e = model(64'h1, 2'b10, 0, 5);
    send_one(64'h1, 2'b10, 0, 5, e[71:64], got);
    chk("inj_double_par", 80'(^got[71:0]), 80'(0));
    chk("inj_double_code", got, e);
    // Double with equal positions flips once
    e = model(64'h1, 2'b10, 9, 9);
    send_one(64'h1, 2'b10, 9, 9, e[71:64], got);
    chk("inj_same_par", 80'(^got[71:0]), 80'(1));
    // Out-of-range position and mode 11 leave the codeword clean
    e = model(64'h1, 2'b00, 0, 0);
    send_one(64'h1, 2'b01, 100, 0, e[71:64], got);
    chk("inj_oor_code", got, e);
    send_one(64'h1, 2'b11, 3, 5, e[71:64], got);
    chk("inj_mode11_code", got, e);
`endif

    wait_drain("final_drain");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
